// File: rtl/if_stage.sv
// Instruction fetch: assembles 32-bit words from a byte-wide memory port.
// Define IF_ICACHE_EN to add a 16-entry direct-mapped word cache.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_din_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_LAST,
    S_FULL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  pidx_q, pidx_d;
  logic [31:0] asm_q, asm_d;
  logic        vld_q, vld_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  logic        accept;
  logic        hit;
  logic [31:0] hit_word;
  logic        req;
  logic        gnt;

  assign accept = (state_q == S_FULL) && !stall_i;

`ifdef IF_ICACHE_EN
  logic [25:0] tag_q [16];
  logic [31:0] data_q [16];
  logic [15:0] cv_q;
  logic [3:0]  idx;
  logic        lookup;
  logic        fill;

  assign idx    = fpc_q[5:2];
  assign lookup = !jump_i &&
                  (((state_q == S_ISSUE) && (cnt_q == 2'd0) && !pend_q)
                   || accept);
  assign hit      = lookup && cv_q[idx] && (tag_q[idx] == fpc_q[31:6]);
  assign hit_word = data_q[idx];
  assign fill     = (state_q == S_LAST) && pend_q && !jump_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cv_q <= '0;
    end else if (fill) begin
      cv_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx]  <= fpc_q[31:6];
      data_q[idx] <= {mem_din_i, asm_q[23:0]};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  // Byte 0 of the next word is requested in the same cycle FULL is accepted.
  assign req = rst && !jump_i && !hit &&
               ((state_q == S_ISSUE) || accept);
  assign gnt = req && mem_gnt_i;

  assign mem_rd_o   = req;
  assign mem_addr_o = rst ? (fpc_q + {30'b0, cnt_q}) : 32'h0;

  assign inst_valid_o = vld_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    pidx_d  = pidx_q;
    asm_d   = asm_q;
    vld_d   = vld_q;
    pc_d    = pc_q;
    inst_d  = inst_q;

    if (pend_q) begin
      asm_d[{pidx_q, 3'b000} +: 8] = mem_din_i;
    end

    if (gnt) begin
      pend_d = 1'b1;
      pidx_d = cnt_q;
      cnt_d  = cnt_q + 2'd1;
    end

    unique case (state_q)
      S_ISSUE: begin
        if (hit) begin
          vld_d   = 1'b1;
          pc_d    = fpc_q;
          inst_d  = hit_word;
          fpc_d   = fpc_q + 32'd4;
          state_d = S_FULL;
        end else if (gnt && (cnt_q == 2'd3)) begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        if (pend_q) begin
          vld_d   = 1'b1;
          pc_d    = fpc_q;
          inst_d  = {mem_din_i, asm_q[23:0]};
          fpc_d   = fpc_q + 32'd4;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (accept) begin
          if (hit) begin
            pc_d   = fpc_q;
            inst_d = hit_word;
            fpc_d  = fpc_q + 32'd4;
          end else begin
            vld_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase

    // Redirect drops any in-flight byte and restarts on the aligned target.
    if (jump_i) begin
      fpc_d   = {jump_addr_i[31:2], 2'b00};
      state_d = S_ISSUE;
      cnt_d   = 2'd0;
      pend_d  = 1'b0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_ISSUE;
      fpc_q   <= RESET_PC;
      cnt_q   <= 2'd0;
      pend_q  <= 1'b0;
      pidx_q  <= 2'd0;
      asm_q   <= '0;
      vld_q   <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
      asm_q   <= asm_d;
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RISC-V pipeline, directly upstream of instruction decode. It fetches 32-bit little-endian instruction words through the shared byte-wide memory port, one byte per granted cycle. It holds each completed word with its PC until the downstream pipeline accepts it, and redirects on taken jumps/branches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low (rst == 0 resets).
- stall_i  in  1  downstream stall; the held word is accepted in any cycle with inst_valid_o=1 and stall_i=0.
- jump_i  in  1  redirect request from EX.
- jump_addr_i  in  32  redirect target; bits [1:0] are forced to 0.
- mem_gnt_i  in  1  arbiter grant; a byte read is issued only when mem_rd_o=1 and mem_gnt_i=1.
- mem_din_i  in  8  read data; valid the cycle after the issuing cycle.
- mem_rd_o  out  1  byte read request.
- mem_addr_o  out  32  byte address; meaningful only when mem_rd_o=1.
- inst_valid_o  out  1  pc_o/inst_o hold a complete word.
- pc_o  out  32  address of the held word.
- inst_o  out  32  held instruction; byte at pc+k maps to bits [8k+7:8k].

## Operation
- State:
  - fetch_pc (32)
  - FSM {ISSUE, LAST, FULL}
  - issue count cnt (2 bits)
  - pending flag plus pending byte index (tracks a byte issued last cycle)
  - assembly register (32)
  - output registers
- Reset values:
  - fetch_pc=RESET_PC, state=ISSUE, cnt=0, pending=0.
  - inst_valid_o=0, pc_o=0, inst_o=0.
  - mem_rd_o=0, mem_addr_o=0 while rst=0.
- ISSUE:
  - mem_rd_o=1, mem_addr_o=fetch_pc+cnt.
  - On grant: cnt++ and set pending with index cnt.
  - Granting byte 3 moves to LAST.
- LAST:
  - No request; waits for pending byte 3.
  - On capture: word and fetch_pc go to the output registers, fetch_pc+=4, state=FULL.
- Byte capture (any state): if pending, mem_din_i goes into assembly byte [index]. pending clears unless a new grant occurs the same cycle.
- FULL:
  - inst_valid_o=1.
  - stall_i=1: outputs held, mem_rd_o=0.
  - stall_i=0: word accepted; byte 0 of fetch_pc is requested the same cycle. If granted, go to ISSUE with cnt=1; otherwise go to ISSUE with cnt=0. inst_valid_o=0 next cycle.
- Grant low: request and address held, cnt unchanged; an already pending byte is still captured.
- Redirect (jump_i=1):
  - Highest priority, overrides stall_i and gnt.
  - mem_rd_o=0 that cycle.
  - Next cycle: fetch_pc=jump_addr_i&~3, state=ISSUE, cnt=0, pending=0 (the in-flight byte is discarded), inst_valid_o=0.
- Address arithmetic is 32-bit modulo; fetch_pc+4 wraps from 0xFFFF_FFFC to 0.

## Timing
- Cold fetch with grant always high:
  - Bytes are requested in cycles c0..c3; LAST is c4; inst_valid_o=1 in c5.
  - With no stall, throughput is 5 cycles per instruction (byte 0 of the next word overlaps FULL).
- Each grant-low cycle during ISSUE adds exactly one cycle.
- Redirect asserted in cycle t: new address presented at t+1; first valid word at t+6 (miss).
- Outputs change only on clk rising edge or rst assertion. mem_rd_o/mem_addr_o are combinational from state, stall_i and jump_i.

## Configuration
- IF_ICACHE_EN defined:
  - 16-entry direct-mapped word cache: index pc[5:2], tag pc[31:6], per-entry valid bits cleared by rst.
  - Lookup occurs in ISSUE with cnt=0 and pending=0, and in FULL when the word is accepted.
  - Hit: no memory request; the word goes to output next cycle (FULL), giving 1 instruction per cycle on consecutive hits.
  - Miss: normal byte fetch; completion fills the entry.
  - A redirect to a cached address yields inst_valid_o at t+2.
- IF_ICACHE_EN undefined: no cache storage; every word is fetched from memory as above.

## Test plan
- Reset release, grant high, mem[0..3]=93 00 10 00 -> addresses 0,1,2,3 in c0..c3; c5 has inst_valid_o=1, pc_o=0, inst_o=0x00100093.
- stall_i=1 for 3 cycles in FULL -> outputs stable and mem_rd_o=0; stall release -> address 4 requested in the same cycle, inst_valid_o=0 next cycle.
- mem_gnt_i=0 for 2 cycles while address 2 is requested -> address 2 held; word still correct; valid at c7.
- jump_i=1, jump_addr_i=0x102 while cnt=2 -> next cycle address 0x100; byte from address 1 discarded; pc_o=0x100 with correct word at t+6.
- jump_i while FULL with stall_i=1 -> inst_valid_o=0 next cycle; fetch restarts at target.
- IF_ICACHE_EN: fetch 0x0, then redirect to 0x0 -> valid at t+2, no mem_rd_o; assert rst -> valid bits cleared, next fetch of 0x0 goes to memory.
